// File: rtl/tick_debouncer.sv
// Tick-paced button debouncer: 2-FF synchroniser, four-state window FSM, rise/fall strobes.
// Define TICK_DEBOUNCER_PRESS_CNT_EN to add the 8-bit press_cnt output.
module tick_debouncer #(
   parameter int unsigned STABLE_TICKS = 4
) (
   input  logic       clk50m,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic       sample_tick,
   output logic       btn_level,
   output logic       btn_rise,
   output logic       btn_fall
`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
   ,
   output logic [7:0] press_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(STABLE_TICKS + 1);
   localparam logic [CNT_W-1:0] CntLast = CNT_W'(STABLE_TICKS - 1);

   localparam logic [1:0] StLowStable  = 2'd0;
   localparam logic [1:0] StLowWait    = 2'd1;
   localparam logic [1:0] StHighStable = 2'd2;
   localparam logic [1:0] StHighWait   = 2'd3;

   logic             s1_q, s2_q;
   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
      end else begin
         s1_q <= btn_raw;
         s2_q <= s1_q;
      end
   end

   // A bounce (s2 back at the stable level) takes priority over a tick in the same cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      case (state_q)
         StLowStable: begin
            if (s2_q) begin
               state_d = StLowWait;
               cnt_d   = '0;
            end
         end
         StLowWait: begin
            if (!s2_q) begin
               state_d = StLowStable;
               cnt_d   = '0;
            end else if (sample_tick && (cnt_q == CntLast)) begin
               state_d = StHighStable;
               cnt_d   = '0;
               level_d = 1'b1;
               rise_d  = 1'b1;
            end else if (sample_tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         StHighStable: begin
            if (!s2_q) begin
               state_d = StHighWait;
               cnt_d   = '0;
            end
         end
         StHighWait: begin
            if (s2_q) begin
               state_d = StHighStable;
               cnt_d   = '0;
            end else if (sample_tick && (cnt_q == CntLast)) begin
               state_d = StLowStable;
               cnt_d   = '0;
               level_d = 1'b0;
               fall_d  = 1'b1;
            end else if (sample_tick) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = StLowStable;
            cnt_d   = '0;
            level_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StLowStable;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign btn_level = level_q;
   assign btn_rise  = rise_q;
   assign btn_fall  = fall_q;

`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
   logic [7:0] press_q, press_d;

   // Counts on rise_d so the new value appears in the same clock as btn_rise.
   always_comb begin
      press_d = press_q;
      if (rise_d) begin
         press_d = press_q + 8'd1;
      end
   end

   always_ff @(posedge clk50m or negedge rst_n) begin
      if (!rst_n) begin
         press_q <= 8'd0;
      end else begin
         press_q <= press_d;
      end
   end

   assign press_cnt = press_q;
`endif

endmodule

// File: tb/tb_tick_debouncer.sv
// Directed bench for tick_debouncer: a 4-tick instance driven by a manual tick and a
// 1-tick instance with sample_tick tied high; press_cnt checks under TICK_DEBOUNCER_PRESS_CNT_EN.
module tb_tick_debouncer;

   logic clk50m = 1'b0;
   always #10 clk50m = ~clk50m;

   logic rst_n, btn_raw, sample_tick, btn_raw1;
   logic btn_level, btn_rise, btn_fall;
   logic btn_level1, btn_rise1, btn_fall1;
`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
   logic [7:0] press_cnt, press_cnt1;
`endif

   int n_checks = 0;
   int n_pass   = 0;
   int n_rise = 0, n_fall = 0, n_rise1 = 0, n_fall1 = 0;
   int exp_rise = 0, exp_fall = 0, exp_press = 0, exp_press1 = 0;
   bit both_high = 1'b0;

   tick_debouncer #(.STABLE_TICKS(4)) dut (
      .clk50m      (clk50m),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw),
      .sample_tick (sample_tick),
      .btn_level   (btn_level),
      .btn_rise    (btn_rise),
      .btn_fall    (btn_fall)
`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
      ,
      .press_cnt   (press_cnt)
`endif
   );

   tick_debouncer #(.STABLE_TICKS(1)) dut1 (
      .clk50m      (clk50m),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw1),
      .sample_tick (1'b1),
      .btn_level   (btn_level1),
      .btn_rise    (btn_rise1),
      .btn_fall    (btn_fall1)
`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
      ,
      .press_cnt   (press_cnt1)
`endif
   );

   // Pulse counters sampled on the falling edge, away from the active edge.
   always @(negedge clk50m) begin
      if (btn_rise === 1'b1)  n_rise++;
      if (btn_fall === 1'b1)  n_fall++;
      if (btn_rise1 === 1'b1) n_rise1++;
      if (btn_fall1 === 1'b1) n_fall1++;
      if ((btn_rise && btn_fall) || (btn_rise1 && btn_fall1)) both_high = 1'b1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_press(input string tag);
`ifdef TICK_DEBOUNCER_PRESS_CNT_EN
      check(tag, 32'(press_cnt), 32'(8'(exp_press)));
      check({tag, "_1"}, 32'(press_cnt1), 32'(8'(exp_press1)));
`else
      n_checks = n_checks + 0;
`endif
   endtask

   task automatic clk_n(input int n);
      repeat (n) begin
         @(posedge clk50m);
         #1;
      end
   endtask

   // Nine idle clocks then one clock with sample_tick high; returns just after the tick edge.
   task automatic do_tick();
      clk_n(9);
      sample_tick = 1'b1;
      clk_n(1);
      sample_tick = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      btn_raw     = 1'b0;
      btn_raw1    = 1'b0;
      sample_tick = 1'b0;
      #5;
      check("reset_level", 32'(btn_level), 0);
      check("reset_rise", 32'(btn_rise), 0);
      check("reset_fall", 32'(btn_fall), 0);
      check("reset_level1", 32'(btn_level1), 0);
      chk_press("reset_press");
      clk_n(2);
      rst_n = 1'b1;
      clk_n(2);

      // ST=1, tick tied high: 4-clock latency
      btn_raw1 = 1'b1;
      clk_n(3);
      check("lat1_level_early", 32'(btn_level1), 0);
      clk_n(1);
      check("lat1_level", 32'(btn_level1), 1);
      check("lat1_rise", 32'(btn_rise1), 1);
      exp_press1++;
      chk_press("lat1_press");
      clk_n(1);
      check("lat1_rise_gone", 32'(btn_rise1), 0);

      // Clean press
      btn_raw = 1'b1;
      clk_n(3);
      repeat (3) do_tick();
      check("press_level_3ticks", 32'(btn_level), 0);
      do_tick();
      check("press_level", 32'(btn_level), 1);
      check("press_rise", 32'(btn_rise), 1);
      check("press_fall", 32'(btn_fall), 0);
      exp_rise++;
      exp_press++;
      chk_press("press_cnt");
      clk_n(1);
      check("press_rise_gone", 32'(btn_rise), 0);
      check("press_level_hold", 32'(btn_level), 1);
      check("press_nrise", 32'(n_rise), 32'(exp_rise));
      check("press_nfall", 32'(n_fall), 32'(exp_fall));

      // Release
      btn_raw = 1'b0;
      clk_n(3);
      repeat (3) do_tick();
      check("rel_level_3ticks", 32'(btn_level), 1);
      do_tick();
      check("rel_level", 32'(btn_level), 0);
      check("rel_fall", 32'(btn_fall), 1);
      check("rel_rise", 32'(btn_rise), 0);
      exp_fall++;
      chk_press("rel_press");
      clk_n(1);
      check("rel_fall_gone", 32'(btn_fall), 0);

      // Bounce after 3 ticks aborts the window
      btn_raw = 1'b1;
      clk_n(3);
      repeat (3) do_tick();
      btn_raw = 1'b0;
      clk_n(1);
      btn_raw = 1'b1;
      clk_n(3);
      do_tick();
      check("bounce_no_edge", 32'(btn_level), 0);
      repeat (2) do_tick();
      check("bounce_level_3new", 32'(btn_level), 0);
      do_tick();
      check("bounce_level", 32'(btn_level), 1);
      check("bounce_rise", 32'(btn_rise), 1);
      exp_rise++;
      exp_press++;
      clk_n(1);
      check("bounce_nrise", 32'(n_rise), 32'(exp_rise));
      btn_raw = 1'b0;
      clk_n(3);
      repeat (4) do_tick();
      check("bounce_rel_level", 32'(btn_level), 0);
      exp_fall++;

      // s2 reverts in the same clock as the final tick
      btn_raw = 1'b1;
      clk_n(3);
      repeat (3) do_tick();
      clk_n(7);
      btn_raw = 1'b0;
      clk_n(1);
      btn_raw = 1'b1;
      clk_n(1);
      sample_tick = 1'b1;
      clk_n(1);
      sample_tick = 1'b0;
      check("simul_level", 32'(btn_level), 0);
      check("simul_rise", 32'(btn_rise), 0);
      clk_n(1);
      repeat (3) do_tick();
      check("simul_fresh_window", 32'(btn_level), 0);
      do_tick();
      check("simul_level_final", 32'(btn_level), 1);
      exp_rise++;
      exp_press++;
      chk_press("simul_press");
      btn_raw = 1'b0;
      clk_n(3);
      repeat (4) do_tick();
      check("simul_rel_level", 32'(btn_level), 0);
      exp_fall++;
      clk_n(1);
      check("simul_nrise", 32'(n_rise), 32'(exp_rise));
      check("simul_nfall", 32'(n_fall), 32'(exp_fall));

      // Reset mid-window, with dut1 currently high
      check("pre_rst_level1", 32'(btn_level1), 1);
      btn_raw = 1'b1;
      clk_n(3);
      repeat (2) do_tick();
      clk_n(3);
      #4;
      rst_n    = 1'b0;
      btn_raw1 = 1'b0;
      #2;
      check("rst_level", 32'(btn_level), 0);
      check("rst_rise", 32'(btn_rise), 0);
      check("rst_fall", 32'(btn_fall), 0);
      check("rst_level1", 32'(btn_level1), 0);
      exp_press  = 0;
      exp_press1 = 0;
      chk_press("rst_press");
      clk_n(2);
      rst_n = 1'b1;
      // Tick coincides with the LOW_WAIT entry clock and must not count
      clk_n(2);
      sample_tick = 1'b1;
      clk_n(1);
      sample_tick = 1'b0;
      repeat (3) do_tick();
      check("rst_rel_level_3ticks", 32'(btn_level), 0);
      do_tick();
      check("rst_rel_level", 32'(btn_level), 1);
      check("rst_rel_rise", 32'(btn_rise), 1);
      exp_rise++;
      exp_press++;
      chk_press("rst_rel_press");
      btn_raw = 1'b0;
      clk_n(3);
      repeat (4) do_tick();
      exp_fall++;

      // 257 press/release cycles on dut1: press_cnt wraps to 1
      repeat (257) begin
         btn_raw1 = 1'b1;
         clk_n(6);
         btn_raw1 = 1'b0;
         clk_n(6);
      end
      exp_press1 += 257;
      chk_press("wrap_press");
      check("wrap_level1", 32'(btn_level1), 0);
      check("wrap_nrise1", 32'(n_rise1), 258);
      check("wrap_nfall1", 32'(n_fall1), 257);
      check("final_nrise", 32'(n_rise), 32'(exp_rise));
      check("final_nfall", 32'(n_fall), 32'(exp_fall));
      check("never_both_high", 32'(both_high), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/tick_debouncer.md
Name: tick_debouncer

Overview:
- Conditions a raw, asynchronous push-button or switch input into a clean level.
- Also produces single-cycle rise and fall strobes.
- Sits upstream of the D-FF/shift-register stage and drives its data input.
- Consumes a one-cycle sample strobe, for example the counter's zero tick, as its time base, so the debounce window is expressed in ticks, not clocks.

Parameters:
STABLE_TICKS, 4, number of consecutive sample ticks the synchronised input must hold a new value before it is accepted; legal range 1..65535
CNT_W, $clog2(STABLE_TICKS+1), width of the internal tick counter; derived, not overridden

Ports:
clk50m  input  1  50 MHz system clock, all logic on posedge
rst_n  input  1  asynchronous active-low reset
btn_raw  input  1  raw asynchronous button/switch level
sample_tick  input  1  one-clock-wide sample strobe, synchronous to clk50m
btn_level  output  1  debounced level
btn_rise  output  1  one-cycle pulse on accepted 0->1 change
btn_fall  output  1  one-cycle pulse on accepted 1->0 change
press_cnt  output  8  accepted rise count; present only with TICK_DEBOUNCER_PRESS_CNT_EN

Behaviour:
- Reset (rst_n=0, async):
  - sync flops = 0, state = LOW_STABLE, counter = 0.
  - btn_level = 0, btn_rise = 0, btn_fall = 0, press_cnt = 0.
- Synchroniser: 2-FF chain btn_raw -> s1 -> s2; only s2 is used downstream. Latency is 2 clocks.
- FSM states: LOW_STABLE, LOW_WAIT, HIGH_STABLE, HIGH_WAIT. All transitions are registered.
- LOW_STABLE:
  - s2=1 -> LOW_WAIT, counter=0. Entry needs no tick.
  - A tick in the entry cycle is not counted.
- LOW_WAIT:
  - s2=0 -> LOW_STABLE, counter=0. A bounce aborts the window, even in the same cycle as a tick.
  - Else if sample_tick and counter==STABLE_TICKS-1 -> HIGH_STABLE; btn_level<=1; btn_rise<=1 for exactly one clock.
  - Else if sample_tick -> counter+1.
  - Else hold.
- HIGH_STABLE / HIGH_WAIT: mirror of the above with s2 polarity inverted. The accepting transition drives btn_level<=0 and btn_fall<=1.
- Pulse timing:
  - btn_rise/btn_fall assert in the same clock btn_level changes, i.e. the clock after the accepting tick.
  - They are low in every other cycle and never both high.
- Latency: 2 clocks plus the time to STABLE_TICKS ticks sampled while in the WAIT state plus 1 clock.
- STABLE_TICKS=1: the first tick seen in WAIT accepts.
- sample_tick held high continuously: counts every clock. This is legal; the window becomes STABLE_TICKS clocks.
- Counter: never exceeds STABLE_TICKS-1; no wrap; cleared on every STABLE entry.
- Reset asserted mid-window: everything returns to reset values immediately, no pulse. After release with btn_raw=1, a full window is required before btn_level=1.

Optional Feature:
- Macro: TICK_DEBOUNCER_PRESS_CNT_EN.
- Defined:
  - port press_cnt[7:0] exists; it increments by 1 in the same clock btn_rise is asserted.
  - It wraps 255->0 and resets to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Clean press: STABLE_TICKS=4, tick every 10 clocks, btn_raw 0->1 and held -> btn_level=1 with one btn_rise pulse exactly 1 clock after the 4th tick counted in LOW_WAIT; btn_fall stays 0.
- Bounce abort: btn_raw high for 3 ticks then low 1 clock then high -> no edge at the 4th tick; a new 4-tick window starts, and btn_rise fires only after 4 further ticks.
- Release: from btn_level=1, btn_raw 1->0 held -> btn_level=0 with one btn_fall pulse after 4 ticks; press_cnt (macro on) unchanged.
- Simultaneous bounce and final tick: s2 reverts in the same clock as the 4th tick -> state returns to LOW_STABLE, btn_level stays 0, no pulse.
- Reset mid-window: rst_n low after 2 ticks in LOW_WAIT -> all outputs 0 asynchronously. After release with btn_raw=1, btn_rise occurs only after 2 sync clocks plus 4 fresh ticks.
- Macro on: 257 clean press/release cycles -> press_cnt=1; STABLE_TICKS=1 with sample_tick tied high -> btn_level follows btn_raw with 4-clock latency.
